// File: rtl/exu_div_pipe1.sv
`default_nettype none
// ============================================================================
// Module   : exu_div_pipe1
// Function : Iterative RV64M divide/remainder unit on execution pipe 1.
//            Radix-2 restoring division, one quotient bit per cycle.
//            Divide-by-zero and signed overflow finish in a single cycle.
//            The result is presented on a combinational EX forwarding bus
//            in the DONE cycle and on a registered CDB bus one cycle later.
// Revision : 1.0  initial release
// ============================================================================
module exu_div_pipe1 (
    input  logic        clk,
    input  logic        rst_clk,
    input  logic        rtu_global_flush,
    input  logic        pipe1_vld,
    input  logic [4:0]  pipe1_iid,
    input  logic [6:0]  pipe1_opcode,
    input  logic [6:0]  pipe1_funct7,
    input  logic [2:0]  pipe1_funct3,
    input  logic [63:0] pipe1_psrc1_value,
    input  logic [63:0] pipe1_psrc2_value,
    input  logic        pipe1_pdst_vld,
    input  logic [5:0]  pipe1_pdst,
    output logic        exu_div_busy,
    output logic        exu_idu_rf_div_ex_vld,
    output logic [5:0]  exu_idu_rf_div_ex_preg,
    output logic [63:0] exu_idu_rf_div_ex_result,
    output logic        exu_idu_rf_div_cdb_vld,
    output logic [5:0]  exu_idu_rf_div_cdb_preg,
    output logic [63:0] exu_idu_rf_div_cdb_result,
    output logic [4:0]  exu_idu_rf_div_cdb_iid
);

    localparam logic [6:0]  c_opc_op    = 7'b0110011;
    localparam logic [6:0]  c_opc_op32  = 7'b0111011;
    localparam logic [6:0]  c_funct7_m  = 7'b0000001;
    localparam logic [63:0] c_min_dword = 64'h8000_0000_0000_0000;
    localparam logic [63:0] c_min_word  = 64'hFFFF_FFFF_8000_0000;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CALC = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t      r_state;
    state_t      w_state_nxt;

    // Latched instruction context
    logic [4:0]  r_iid;
    logic [5:0]  r_pdst;
    logic        r_pdst_vld;
    logic        r_is_rem;
    logic        r_is_word;
    logic        r_neg_q;
    logic        r_neg_r;

    // Datapath: r_quo shifts the dividend out and the quotient in
    logic [63:0] r_quo;
    logic [63:0] r_rem;
    logic [63:0] r_dvs;
    logic [5:0]  r_cnt;

    // Decode and operand preparation
    logic        w_is_word;
    logic        w_is_div;
    logic        w_accept;
    logic        w_unsigned;
    logic        w_rem_op;
    logic [63:0] w_src1_ext;
    logic [63:0] w_src2_ext;
    logic        w_src1_neg;
    logic        w_src2_neg;
    logic [63:0] w_src1_abs;
    logic [63:0] w_src2_abs;
    logic        w_div_zero;
    logic        w_ovf;
    logic        w_special;

    assign w_is_word  = (pipe1_opcode == c_opc_op32);
    assign w_is_div   = pipe1_vld && (pipe1_funct7 == c_funct7_m) && pipe1_funct3[2]
                        && ((pipe1_opcode == c_opc_op) || w_is_word);
    assign w_accept   = w_is_div && (r_state == ST_IDLE) && !rtu_global_flush;
    assign w_unsigned = pipe1_funct3[0];
    assign w_rem_op   = pipe1_funct3[1];

    assign w_src1_ext = !w_is_word ? pipe1_psrc1_value :
                        w_unsigned ? {32'd0, pipe1_psrc1_value[31:0]} :
                                     {{32{pipe1_psrc1_value[31]}}, pipe1_psrc1_value[31:0]};
    assign w_src2_ext = !w_is_word ? pipe1_psrc2_value :
                        w_unsigned ? {32'd0, pipe1_psrc2_value[31:0]} :
                                     {{32{pipe1_psrc2_value[31]}}, pipe1_psrc2_value[31:0]};

    assign w_src1_neg = !w_unsigned && w_src1_ext[63];
    assign w_src2_neg = !w_unsigned && w_src2_ext[63];
    assign w_src1_abs = w_src1_neg ? (~w_src1_ext + 64'd1) : w_src1_ext;
    assign w_src2_abs = w_src2_neg ? (~w_src2_ext + 64'd1) : w_src2_ext;

    assign w_div_zero = (w_src2_ext == 64'd0);
    assign w_ovf      = !w_unsigned && (w_src2_ext == {64{1'b1}})
                        && (w_src1_ext == (w_is_word ? c_min_word : c_min_dword));
    assign w_special  = w_div_zero || w_ovf;

    // One restoring step: trial-subtract the divisor from the shifted remainder
    logic [64:0] w_shift;
    logic [64:0] w_diff;
    logic        w_qbit;
    logic [63:0] w_rem_nxt;

    assign w_shift   = {r_rem, r_quo[63]};
    assign w_diff    = w_shift - {1'b0, r_dvs};
    assign w_qbit    = ~w_diff[64];
    assign w_rem_nxt = w_qbit ? w_diff[63:0] : w_shift[63:0];

    // State register
    always_ff @(posedge clk or negedge rst_clk) begin
        if (!rst_clk) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic; flush overrides every transition
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: begin
                if (w_accept) begin
                    w_state_nxt = w_special ? ST_DONE : ST_CALC;
                end
            end
            ST_CALC: begin
                if (r_cnt == 6'd0) begin
                    w_state_nxt = ST_DONE;
                end
            end
            ST_DONE: begin
                w_state_nxt = ST_IDLE;
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
        if (rtu_global_flush) begin
            w_state_nxt = ST_IDLE;
        end
    end

    // Operand latch on accept, one quotient bit per CALC cycle
    always_ff @(posedge clk or negedge rst_clk) begin
        if (!rst_clk) begin
            r_iid      <= 5'd0;
            r_pdst     <= 6'd0;
            r_pdst_vld <= 1'b0;
            r_is_rem   <= 1'b0;
            r_is_word  <= 1'b0;
            r_neg_q    <= 1'b0;
            r_neg_r    <= 1'b0;
            r_quo      <= 64'd0;
            r_rem      <= 64'd0;
            r_dvs      <= 64'd0;
            r_cnt      <= 6'd0;
        end else if (w_accept) begin
            r_iid      <= pipe1_iid;
            r_pdst     <= pipe1_pdst;
            r_pdst_vld <= pipe1_pdst_vld;
            r_is_rem   <= w_rem_op;
            r_is_word  <= w_is_word;
            r_dvs      <= w_src2_abs;
            if (w_special) begin
                // Final values stored directly; no sign fix-up applies
                r_quo   <= w_div_zero ? {64{1'b1}} : w_src1_ext;
                r_rem   <= w_div_zero ? w_src1_ext : 64'd0;
                r_neg_q <= 1'b0;
                r_neg_r <= 1'b0;
                r_cnt   <= 6'd0;
            end else begin
                // Word dividends are pre-aligned to the top so 32 steps suffice
                r_quo   <= w_is_word ? {w_src1_abs[31:0], 32'd0} : w_src1_abs;
                r_rem   <= 64'd0;
                r_neg_q <= w_src1_neg ^ w_src2_neg;
                r_neg_r <= w_src1_neg;
                r_cnt   <= w_is_word ? 6'd31 : 6'd63;
            end
        end else if (r_state == ST_CALC) begin
            r_rem <= w_rem_nxt;
            r_quo <= {r_quo[62:0], w_qbit};
            r_cnt <= r_cnt - 6'd1;
        end
    end

    // Result select, sign fix-up and word sign extension
    logic [63:0] w_sel;
    logic        w_neg;
    logic [63:0] w_fix;
    logic [63:0] w_res;
    logic        w_ex_vld;

    assign w_sel    = r_is_rem ? r_rem : r_quo;
    assign w_neg    = r_is_rem ? r_neg_r : r_neg_q;
    assign w_fix    = w_neg ? (~w_sel + 64'd1) : w_sel;
    assign w_res    = r_is_word ? {{32{w_fix[31]}}, w_fix[31:0]} : w_fix;
    assign w_ex_vld = (r_state == ST_DONE) && r_pdst_vld;

    assign exu_div_busy             = (r_state != ST_IDLE);
    assign exu_idu_rf_div_ex_vld    = w_ex_vld;
    assign exu_idu_rf_div_ex_preg   = w_ex_vld ? r_pdst : 6'd0;
    assign exu_idu_rf_div_ex_result = w_ex_vld ? w_res : 64'd0;

    // CDB beat: registered copy of the EX bus, dropped on flush
    always_ff @(posedge clk or negedge rst_clk) begin
        if (!rst_clk) begin
            exu_idu_rf_div_cdb_vld    <= 1'b0;
            exu_idu_rf_div_cdb_preg   <= 6'd0;
            exu_idu_rf_div_cdb_result <= 64'd0;
            exu_idu_rf_div_cdb_iid    <= 5'd0;
        end else if (rtu_global_flush) begin
            exu_idu_rf_div_cdb_vld    <= 1'b0;
            exu_idu_rf_div_cdb_preg   <= 6'd0;
            exu_idu_rf_div_cdb_result <= 64'd0;
            exu_idu_rf_div_cdb_iid    <= 5'd0;
        end else begin
            exu_idu_rf_div_cdb_vld    <= w_ex_vld;
            exu_idu_rf_div_cdb_preg   <= exu_idu_rf_div_ex_preg;
            exu_idu_rf_div_cdb_result <= exu_idu_rf_div_ex_result;
            exu_idu_rf_div_cdb_iid    <= w_ex_vld ? r_iid : 5'd0;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_exu_div_pipe1.sv
`default_nettype none
// ============================================================================
// Module   : tb_exu_div_pipe1
// Function : Self-checking bench for exu_div_pipe1. An arithmetic reference
//            model with a cycle-count latency predicts both result buses,
//            checked every cycle, plus directed literal expectations.
// Revision : 1.0  initial release
// ============================================================================
module tb_exu_div_pipe1;

    localparam logic [6:0] OPC_OP   = 7'b0110011;
    localparam logic [6:0] OPC_OP32 = 7'b0111011;
    localparam logic [6:0] F7_M     = 7'b0000001;

    logic        clk = 1'b0;
    logic        rst_clk = 1'b0;
    logic        rtu_global_flush = 1'b0;
    logic        pipe1_vld = 1'b0;
    logic [4:0]  pipe1_iid = '0;
    logic [6:0]  pipe1_opcode = '0;
    logic [6:0]  pipe1_funct7 = '0;
    logic [2:0]  pipe1_funct3 = '0;
    logic [63:0] pipe1_psrc1_value = '0;
    logic [63:0] pipe1_psrc2_value = '0;
    logic        pipe1_pdst_vld = 1'b0;
    logic [5:0]  pipe1_pdst = '0;
    logic        exu_div_busy;
    logic        ex_vld;
    logic [5:0]  ex_preg;
    logic [63:0] ex_result;
    logic        cdb_vld;
    logic [5:0]  cdb_preg;
    logic [63:0] cdb_result;
    logic [4:0]  cdb_iid;

    int n_vec = 0;
    int n_err = 0;

    exu_div_pipe1 dut (
        .clk                       (clk),
        .rst_clk                   (rst_clk),
        .rtu_global_flush          (rtu_global_flush),
        .pipe1_vld                 (pipe1_vld),
        .pipe1_iid                 (pipe1_iid),
        .pipe1_opcode              (pipe1_opcode),
        .pipe1_funct7              (pipe1_funct7),
        .pipe1_funct3              (pipe1_funct3),
        .pipe1_psrc1_value         (pipe1_psrc1_value),
        .pipe1_psrc2_value         (pipe1_psrc2_value),
        .pipe1_pdst_vld            (pipe1_pdst_vld),
        .pipe1_pdst                (pipe1_pdst),
        .exu_div_busy              (exu_div_busy),
        .exu_idu_rf_div_ex_vld     (ex_vld),
        .exu_idu_rf_div_ex_preg    (ex_preg),
        .exu_idu_rf_div_ex_result  (ex_result),
        .exu_idu_rf_div_cdb_vld    (cdb_vld),
        .exu_idu_rf_div_cdb_preg   (cdb_preg),
        .exu_idu_rf_div_cdb_result (cdb_result),
        .exu_idu_rf_div_cdb_iid    (cdb_iid)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s @%0t: got %h expected %h", name, $time, act, exp);
        end
    endtask

    // Reference arithmetic: RISC-V M semantics written with plain operators
    function automatic logic [63:0] ext_op(input logic word, input logic uns, input logic [63:0] v);
        if (!word) return v;
        return uns ? {32'd0, v[31:0]} : {{32{v[31]}}, v[31:0]};
    endfunction

    function automatic logic is_special(input logic [2:0] f3, input logic word,
                                        input logic [63:0] a, input logic [63:0] b);
        logic [63:0] ua, ub, mn;
        ua = ext_op(word, f3[0], a);
        ub = ext_op(word, f3[0], b);
        mn = word ? 64'hFFFF_FFFF_8000_0000 : 64'h8000_0000_0000_0000;
        return (ub == 64'd0) || (!f3[0] && ua == mn && ub == {64{1'b1}});
    endfunction

    function automatic logic [63:0] ref_div(input logic [2:0] f3, input logic word,
                                            input logic [63:0] a, input logic [63:0] b);
        logic [63:0] ua, ub, r;
        logic signed [63:0] sa, sb;
        ua = ext_op(word, f3[0], a);
        ub = ext_op(word, f3[0], b);
        sa = ua;
        sb = ub;
        if (ub == 64'd0)
            r = f3[1] ? ua : {64{1'b1}};
        else if (is_special(f3, word, a, b))
            r = f3[1] ? 64'd0 : ua;
        else if (f3[0])
            r = f3[1] ? (ua % ub) : (ua / ub);
        else
            r = f3[1] ? 64'(sa % sb) : 64'(sa / sb);
        if (word) r = {{32{r[31]}}, r[31:0]};
        return r;
    endfunction

    // Cycle-count model: m_left counts busy cycles remaining, 1 means completion
    int          m_left;
    logic [63:0] m_res;
    logic [5:0]  m_pdst;
    logic [4:0]  m_iid;
    logic        m_pvld;
    logic        m_cdb_vld;
    logic [63:0] m_cdb_res;
    logic [5:0]  m_cdb_preg;
    logic [4:0]  m_cdb_iid;
    logic        m_ex_vld;
    logic        tb_divclass;

    assign m_ex_vld    = (m_left == 1) && m_pvld;
    assign tb_divclass = pipe1_vld && pipe1_funct7 == F7_M && pipe1_funct3[2]
                         && (pipe1_opcode == OPC_OP || pipe1_opcode == OPC_OP32);

    // Reference model state update
    always @(posedge clk or negedge rst_clk) begin
        if (!rst_clk) begin
            m_left <= 0; m_res <= '0; m_pdst <= '0; m_iid <= '0; m_pvld <= 1'b0;
            m_cdb_vld <= 1'b0; m_cdb_res <= '0; m_cdb_preg <= '0; m_cdb_iid <= '0;
        end else begin
            m_cdb_vld  <= m_ex_vld && !rtu_global_flush;
            m_cdb_res  <= (m_ex_vld && !rtu_global_flush) ? m_res : 64'd0;
            m_cdb_preg <= (m_ex_vld && !rtu_global_flush) ? m_pdst : 6'd0;
            m_cdb_iid  <= (m_ex_vld && !rtu_global_flush) ? m_iid : 5'd0;
            if (rtu_global_flush)
                m_left <= 0;
            else if (m_left != 0)
                m_left <= m_left - 1;
            else if (tb_divclass) begin
                m_left <= is_special(pipe1_funct3, pipe1_opcode == OPC_OP32,
                                     pipe1_psrc1_value, pipe1_psrc2_value) ? 1 :
                          (pipe1_opcode == OPC_OP32) ? 33 : 65;
                m_res  <= ref_div(pipe1_funct3, pipe1_opcode == OPC_OP32,
                                  pipe1_psrc1_value, pipe1_psrc2_value);
                m_pdst <= pipe1_pdst;
                m_iid  <= pipe1_iid;
                m_pvld <= pipe1_pdst_vld;
            end
        end
    end

    // Per-cycle comparison against the model, away from the active edge
    always @(negedge clk) begin
        check("busy",       {63'd0, exu_div_busy}, {63'd0, m_left != 0});
        check("ex_vld",     {63'd0, ex_vld},       {63'd0, m_ex_vld});
        check("ex_preg",    {58'd0, ex_preg},      m_ex_vld ? {58'd0, m_pdst} : 64'd0);
        check("ex_result",  ex_result,             m_ex_vld ? m_res : 64'd0);
        check("cdb_vld",    {63'd0, cdb_vld},      {63'd0, m_cdb_vld});
        check("cdb_preg",   {58'd0, cdb_preg},     {58'd0, m_cdb_preg});
        check("cdb_result", cdb_result,            m_cdb_res);
        check("cdb_iid",    {59'd0, cdb_iid},      {59'd0, m_cdb_iid});
        check("no_issue_while_busy", {63'd0, tb_divclass && m_left != 0}, 64'd0);
    end

    // Drive one instruction for one cycle; called just after an edge
    task automatic issue(input logic [6:0] opc, input logic [6:0] f7, input logic [2:0] f3,
                         input logic [63:0] a, input logic [63:0] b,
                         input logic [5:0] pd, input logic [4:0] iid, input logic pv);
        pipe1_vld = 1'b1; pipe1_opcode = opc; pipe1_funct7 = f7; pipe1_funct3 = f3;
        pipe1_psrc1_value = a; pipe1_psrc2_value = b;
        pipe1_pdst = pd; pipe1_iid = iid; pipe1_pdst_vld = pv;
        @(posedge clk); #1;
        pipe1_vld = 1'b0;
    endtask

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    typedef struct {
        logic [6:0]  opc;
        logic [6:0]  f7;
        logic [2:0]  f3;
        logic [63:0] a;
        logic [63:0] b;
        logic        pv;
    } vec_t;

    vec_t vecs [10];

    initial begin
        vecs[0] = '{OPC_OP32, F7_M, 3'b100, 64'hFFFF_FFFF_0000_0064, 64'hFFFF_FFFF_FFFF_FFFD, 1'b1};
        vecs[1] = '{OPC_OP32, F7_M, 3'b101, 64'h0000_0000_8000_0000, 64'd2, 1'b1};
        vecs[2] = '{OPC_OP32, F7_M, 3'b111, 64'h1234_5678_9ABC_DEF0, 64'h5555_5555_0000_0000, 1'b1};
        vecs[3] = '{OPC_OP32, F7_M, 3'b100, 64'h0000_0000_8000_0000, 64'h0000_0000_FFFF_FFFF, 1'b1};
        vecs[4] = '{OPC_OP,   F7_M, 3'b110, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2, 1'b1};
        vecs[5] = '{OPC_OP,   F7_M, 3'b111, 64'hDEAD_BEEF_CAFE_F00D, 64'h0000_0001_0000_0003, 1'b1};
        vecs[6] = '{OPC_OP,   F7_M, 3'b100, 64'd77, 64'd5, 1'b0};
        vecs[7] = '{OPC_OP,   F7_M, 3'b000, 64'd77, 64'd5, 1'b1};
        vecs[8] = '{OPC_OP,   7'd0, 3'b100, 64'd77, 64'd5, 1'b1};
        vecs[9] = '{OPC_OP,   F7_M, 3'b101, 64'h8000_0000_0000_0000, 64'h7FFF_FFFF_FFFF_FFFF, 1'b1};

        // Reset state
        cyc(3);
        check("reset_busy",    {63'd0, exu_div_busy}, 64'd0);
        check("reset_ex_vld",  {63'd0, ex_vld},       64'd0);
        check("reset_cdb_vld", {63'd0, cdb_vld},      64'd0);
        rst_clk = 1'b1;
        cyc(2);

        // div 100 / -7 = -14
        issue(OPC_OP, F7_M, 3'b100, 64'd100, 64'hFFFF_FFFF_FFFF_FFF9, 6'd9, 5'd3, 1'b1);
        cyc(63);
        check("div_early_ex_vld", {63'd0, ex_vld}, 64'd0);
        cyc(1);
        check("div_ex_vld",    {63'd0, ex_vld},   64'd1);
        check("div_ex_result", ex_result,         64'hFFFF_FFFF_FFFF_FFF2);
        check("div_ex_preg",   {58'd0, ex_preg},  64'd9);
        cyc(1);
        check("div_cdb_vld",    {63'd0, cdb_vld},  64'd1);
        check("div_cdb_result", cdb_result,        64'hFFFF_FFFF_FFFF_FFF2);
        check("div_cdb_iid",    {59'd0, cdb_iid},  64'd3);
        cyc(2);

        // remw: word dividend -2147483648 rem 3 = -2
        issue(OPC_OP32, F7_M, 3'b110, 64'h0000_0001_8000_0000, 64'd3, 6'd12, 5'd7, 1'b1);
        cyc(32);
        check("remw_ex_vld",    {63'd0, ex_vld}, 64'd1);
        check("remw_ex_result", ex_result,       64'hFFFF_FFFF_FFFF_FFFE);
        cyc(2);

        // divu by zero, single cycle
        issue(OPC_OP, F7_M, 3'b101, 64'h1234, 64'd0, 6'd20, 5'd1, 1'b1);
        check("divu0_ex_vld",    {63'd0, ex_vld}, 64'd1);
        check("divu0_ex_result", ex_result,       64'hFFFF_FFFF_FFFF_FFFF);
        cyc(1);
        check("divu0_cdb_vld",   {63'd0, cdb_vld}, 64'd1);
        cyc(2);

        // rem most-negative / -1 = 0, single cycle
        issue(OPC_OP, F7_M, 3'b110, 64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 6'd21, 5'd2, 1'b1);
        check("removf_ex_vld",    {63'd0, ex_vld}, 64'd1);
        check("removf_ex_result", ex_result,       64'd0);
        cyc(2);

        // Flush mid-CALC, next op accepted the following cycle
        issue(OPC_OP, F7_M, 3'b100, 64'd1000, 64'd7, 6'd30, 5'd4, 1'b1);
        cyc(19);
        rtu_global_flush = 1'b1;
        cyc(1);
        rtu_global_flush = 1'b0;
        check("flush_busy", {63'd0, exu_div_busy}, 64'd0);
        issue(OPC_OP, F7_M, 3'b111, 64'd1000, 64'd7, 6'd31, 5'd5, 1'b1);
        check("post_flush_accept", {63'd0, exu_div_busy}, 64'd1);
        cyc(64);
        check("post_flush_result", ex_result, 64'd6);
        cyc(2);

        // Asynchronous reset mid-CALC
        issue(OPC_OP, F7_M, 3'b100, 64'd5000, 64'd3, 6'd32, 5'd8, 1'b1);
        cyc(9);
        #2 rst_clk = 1'b0;
        #1;
        check("rst_mid_busy",    {63'd0, exu_div_busy}, 64'd0);
        check("rst_mid_cdb_vld", {63'd0, cdb_vld},      64'd0);
        @(posedge clk); #1;
        rst_clk = 1'b1;
        cyc(1);
        issue(OPC_OP, F7_M, 3'b100, 64'hFFFF_FFFF_FFFF_EC78, 64'd3, 6'd33, 5'd9, 1'b1);
        cyc(64);
        check("post_rst_result", ex_result, 64'hFFFF_FFFF_FFFF_F97E);
        cyc(2);

        // Back-to-back: second op issued the cycle after the first's DONE
        issue(OPC_OP, F7_M, 3'b101, 64'hFFFF_FFFF_FFFF_FFFF, 64'd2, 6'd40, 5'd10, 1'b1);
        cyc(64);
        check("b2b_done_busy", {63'd0, exu_div_busy}, 64'd1);
        check("b2b_a_result",  ex_result,             64'h7FFF_FFFF_FFFF_FFFF);
        cyc(1);
        check("b2b_gap_busy",  {63'd0, exu_div_busy}, 64'd0);
        issue(OPC_OP, F7_M, 3'b100, 64'hFFFF_FFFF_FFFF_FF9C, 64'hFFFF_FFFF_FFFF_FFF9, 6'd41, 5'd11, 1'b1);
        check("b2b_b_accept",  {63'd0, exu_div_busy}, 64'd1);
        cyc(64);
        check("b2b_b_result",  ex_result,             64'd14);
        check("b2b_b_preg",    {58'd0, ex_preg},      64'd41);
        cyc(2);

        // Assorted directed vectors checked by the model
        for (int i = 0; i < 10; i++) begin
            issue(vecs[i].opc, vecs[i].f7, vecs[i].f3, vecs[i].a, vecs[i].b,
                  6'(i + 50), 5'(i + 16), vecs[i].pv);
            cyc(68);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
